// File: rtl/wb_pkg.sv
// Shared constants for the MEM/WB write-back stage of the RV32I core:
// datapath widths, write-back source selects and load funct3 encodings.
package wb_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_LOAD = 2'b01;
  localparam logic [1:0] WB_SEL_PC4  = 2'b10;
  localparam logic [1:0] WB_SEL_IMM  = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_load_align.sv
// Combinational load aligner: picks the byte/half addressed by off out of an
// aligned data word, extends it per funct3 and flags misaligned accesses.
module wb_load_align
  import wb_pkg::*;
#(
  parameter int XLEN = wb_pkg::XLEN
) (
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data,
  output logic            misaligned
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = word[{off, 3'b000} +: 8];
  assign w_half = off[1] ? word[16 +: 16] : word[0 +: 16];

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    data       = word;
    misaligned = 1'b0;
    case (funct3)
      F3_LB:  data = {{(XLEN-8){w_byte[7]}}, w_byte};
      F3_LBU: data = {{(XLEN-8){1'b0}}, w_byte};
      F3_LH: begin
        data       = {{(XLEN-16){w_half[15]}}, w_half};
        misaligned = off[0];
      end
      F3_LHU: begin
        data       = {{(XLEN-16){1'b0}}, w_half};
        misaligned = off[0];
      end
      // LW and every unused encoding behave as a full-word load.
      default: begin
        data       = word;
        misaligned = (off != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and write-back logic; drives the register-file
// write port. Optional WB_INSTRET_EN adds a 64-bit retired-instruction counter.
module wb_stage
  import wb_pkg::*;
#(
  parameter int XLEN   = wb_pkg::XLEN,
  parameter int REG_AW = wb_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              mem_valid,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [1:0]        mem_wb_sel,
  input  logic [2:0]        mem_funct3,
  input  logic [XLEN-1:0]   mem_alu_result,
  input  logic [XLEN-1:0]   mem_load_word,
  input  logic [XLEN-1:0]   mem_pc_plus4,
  input  logic [XLEN-1:0]   mem_imm,
  output logic              reg_write,
  output logic [REG_AW-1:0] reg_id_w,
  output logic [XLEN-1:0]   write_data,
  output logic              wb_valid,
  output logic              load_misalign
`ifdef WB_INSTRET_EN
  ,
  output logic [63:0]       instret
`endif
);

  logic              r_valid;
  logic              r_reg_write;
  logic [REG_AW-1:0] r_rd;
  logic [1:0]        r_wb_sel;
  logic [2:0]        r_funct3;
  logic [XLEN-1:0]   r_alu;
  logic [XLEN-1:0]   r_load_word;
  logic [XLEN-1:0]   r_pc_plus4;
  logic [XLEN-1:0]   r_imm;

  logic [XLEN-1:0]   w_load_data;
  logic              w_misaligned;
  logic [XLEN-1:0]   w_sel_data;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_rd        <= '0;
      r_wb_sel    <= '0;
      r_funct3    <= '0;
      r_alu       <= '0;
      r_load_word <= '0;
      r_pc_plus4  <= '0;
      r_imm       <= '0;
    end else if (flush) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_rd        <= '0;
      r_wb_sel    <= '0;
      r_funct3    <= '0;
      r_alu       <= '0;
      r_load_word <= '0;
      r_pc_plus4  <= '0;
      r_imm       <= '0;
    end else if (!stall) begin
      r_valid     <= mem_valid;
      r_reg_write <= mem_reg_write;
      r_rd        <= mem_rd;
      r_wb_sel    <= mem_wb_sel;
      r_funct3    <= mem_funct3;
      r_alu       <= mem_alu_result;
      r_load_word <= mem_load_word;
      r_pc_plus4  <= mem_pc_plus4;
      r_imm       <= mem_imm;
    end
  end

  wb_load_align #(.XLEN(XLEN)) u_align (
    .word       (r_load_word),
    .off        (r_alu[1:0]),
    .funct3     (r_funct3),
    .data       (w_load_data),
    .misaligned (w_misaligned)
  );

  always_comb begin
    w_sel_data = r_alu;
    case (r_wb_sel)
      WB_SEL_LOAD: w_sel_data = w_load_data;
      WB_SEL_PC4:  w_sel_data = r_pc_plus4;
      WB_SEL_IMM:  w_sel_data = r_imm;
      default:     w_sel_data = r_alu;
    endcase
  end

  // Outputs are gated to zero when not writing so forwarding never sees X.
  assign load_misalign = r_valid & (r_wb_sel == WB_SEL_LOAD) & w_misaligned;
  assign reg_write     = r_valid & r_reg_write & (r_rd != '0) & ~load_misalign;
  assign reg_id_w      = reg_write ? r_rd : '0;
  assign write_data    = reg_write ? w_sel_data : '0;
  assign wb_valid      = r_valid;

`ifdef WB_INSTRET_EN
  logic [63:0] r_instret;

  // Count on the edge where the instruction leaves WB, so a stall counts once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instret <= '0;
    end else if (r_valid && (!stall || flush)) begin
      r_instret <= r_instret + 64'd1;
    end
  end

  assign instret = r_instret;
`endif

endmodule
